// File: rtl/alu_issue_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl_if                                            |
// | Description : Bundle of all handshake and bus signals between              |
// |               alu_issue_ctrl and its environment.                          |
// |               Instruction in : in_valid, in_ready, in_instr[31:0]          |
// |               ALU side       : alu_op1, alu_op2, alu_op (to ALU);          |
// |                                alu_result, alu_zero (from ALU)             |
// |               Completion out : out_valid, out_ready, out_result, out_zero, |
// |                                out_rd, out_illegal                         |
// |               Status         : busy                                        |
// |               slave modport  = controller view, master = environment view  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [2:0]  out_rd;
  logic        out_illegal;
  logic        busy;

  modport slave (
    input  in_valid, in_instr, alu_result, alu_zero, out_ready,
    output in_ready, alu_op1, alu_op2, alu_op,
           out_valid, out_result, out_zero, out_rd, out_illegal, busy
  );

  modport master (
    output in_valid, in_instr, alu_result, alu_zero, out_ready,
    input  in_ready, alu_op1, alu_op2, alu_op,
           out_valid, out_result, out_zero, out_rd, out_illegal, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl                                               |
// | Description : Single-issue controller in front of an external              |
// |               combinational ALU. Accepts one instruction, reads operands   |
// |               from an 8x32 register file (r0 hardwired to 0), drives the   |
// |               ALU for exactly one cycle, writes the result back and holds  |
// |               a completion record until the consumer takes it.             |
// |               Ports: clk, rst_n (async, active-low),                       |
// |                      bus (alu_issue_ctrl_if.slave, see interface file)     |
// |               Parameter IMM_SEXT: 0 zero-extends imm16, 1 sign-extends.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl #(
  parameter int IMM_SEXT = 0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  alu_issue_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;

  // Latched instruction fields (only the bits that carry meaning)
  logic [3:0]  opcode_q;
  logic [2:0]  rd_q;
  logic [2:0]  rs1_q;
  logic [2:0]  rs2_q;
  logic        imm_sel_q;
  logic [15:0] imm16_q;

  // r0 is reset to 0 and never written, so a plain array read returns 0 for it
  logic [31:0] rf [8];

  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic        out_zero_q;
  logic [2:0]  out_rd_q;
  logic        out_illegal_q;

  logic        legal;
  logic        in_exec;
  logic [31:0] imm_ext;
  logic        unused_instr_bits;

  assign legal   = ~opcode_q[3];   // opcodes 0..7 are defined
  assign in_exec = (state == S_EXEC);

  assign unused_instr_bits = ^bus.in_instr[17:16];

  generate
    if (IMM_SEXT != 0) begin : g_sext
      assign imm_ext = {{16{imm16_q[15]}}, imm16_q};
    end else begin : g_zext
      assign imm_ext = {16'h0000, imm16_q};
    end
  endgenerate

  // ALU drive is only live during the single EXEC cycle
  assign bus.alu_op  = (in_exec && legal) ? opcode_q : 4'd0;
  assign bus.alu_op1 = in_exec ? rf[rs1_q] : 32'd0;
  assign bus.alu_op2 = in_exec ? (imm_sel_q ? imm_ext : rf[rs2_q]) : 32'd0;

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_illegal = out_illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      opcode_q      <= 4'd0;
      rd_q          <= 3'd0;
      rs1_q         <= 3'd0;
      rs2_q         <= 3'd0;
      imm_sel_q     <= 1'b0;
      imm16_q       <= 16'd0;
      out_valid_q   <= 1'b0;
      out_result_q  <= 32'd0;
      out_zero_q    <= 1'b0;
      out_rd_q      <= 3'd0;
      out_illegal_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf[i] <= 32'd0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            opcode_q  <= bus.in_instr[31:28];
            rd_q      <= bus.in_instr[27:25];
            rs1_q     <= bus.in_instr[24:22];
            rs2_q     <= bus.in_instr[21:19];
            imm_sel_q <= bus.in_instr[18];
            imm16_q   <= bus.in_instr[15:0];
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Illegal opcodes report a clean zero record and never write back
          out_valid_q   <= 1'b1;
          out_result_q  <= legal ? bus.alu_result : 32'd0;
          out_zero_q    <= legal & bus.alu_zero;
          out_rd_q      <= rd_q;
          out_illegal_q <= ~legal;
          if (legal && (rd_q != 3'd0)) begin
            rf[rd_q] <= bus.alu_result;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_ctrl                                            |
// | Description : Directed self-checking bench for alu_issue_ctrl. Two DUTs    |
// |               (IMM_SEXT=0 and 1) share identical stimulus; each has its    |
// |               own behavioural ALU attached.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_alu_issue_ctrl;

  logic clk;
  logic rst_n;

  int tests;
  int fails;

  alu_issue_ctrl_if ifz ();
  alu_issue_ctrl_if ifs ();

  alu_issue_ctrl #(.IMM_SEXT(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifz.slave)
  );

  alu_issue_ctrl #(.IMM_SEXT(1)) u_dut_sext (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return {31'd0, (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  assign ifz.alu_result = alu_f(ifz.alu_op, ifz.alu_op1, ifz.alu_op2);
  assign ifz.alu_zero   = (ifz.alu_result == 32'd0);
  assign ifs.alu_result = alu_f(ifs.alu_op, ifs.alu_op1, ifs.alu_op2);
  assign ifs.alu_zero   = (ifs.alu_result == 32'd0);

  assign ifs.in_valid  = ifz.in_valid;
  assign ifs.in_instr  = ifz.in_instr;
  assign ifs.out_ready = ifz.out_ready;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic isel, input logic [15:0] imm);
    return {op, rd, rs1, rs2, isel, 2'b00, imm};
  endfunction

  // Present instr in IDLE, accept it, then scramble in_instr. Returns #1 into EXEC.
  task automatic send(input logic [31:0] instr);
    @(negedge clk);
    ifz.in_valid = 1'b1;
    ifz.in_instr = instr;
    @(posedge clk);
    #1;
    ifz.in_valid = 1'b0;
    ifz.in_instr = 32'hFFFF_FFFF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    ifz.in_valid  = 1'b0;
    ifz.in_instr  = 32'd0;
    ifz.out_ready = 1'b1;
    #2;
    tests++; if (ifz.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", ifz.in_ready); end
    tests++; if (ifz.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", ifz.busy); end
    tests++; if (ifz.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", ifz.out_valid); end
    tests++; if (ifz.out_result !== 32'd0) begin fails++; $display("FAIL rst_out_result got %h exp 0", ifz.out_result); end
    tests++; if (ifz.out_rd !== 3'd0 || ifz.out_illegal !== 1'b0 || ifz.out_zero !== 1'b0) begin
      fails++; $display("FAIL rst_out_fields got rd=%0d ill=%b z=%b exp 0", ifz.out_rd, ifz.out_illegal, ifz.out_zero); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (ifz.in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready got %b exp 1", ifz.in_ready); end
  endtask

  task automatic test_add_imm();
    send(mk(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005));
    tests++; if (ifz.alu_op1 !== 32'd0) begin fails++; $display("FAIL add_op1 got %h exp 0", ifz.alu_op1); end
    tests++; if (ifz.alu_op2 !== 32'd5) begin fails++; $display("FAIL add_op2 got %h exp 5", ifz.alu_op2); end
    tests++; if (ifz.alu_op !== 4'd0) begin fails++; $display("FAIL add_op got %h exp 0", ifz.alu_op); end
    tests++; if (ifz.busy !== 1'b1 || ifz.in_ready !== 1'b0 || ifz.out_valid !== 1'b0) begin
      fails++; $display("FAIL add_exec_flags got busy=%b rdy=%b ov=%b exp 1 0 0", ifz.busy, ifz.in_ready, ifz.out_valid); end
    step();
    tests++; if (ifz.out_valid !== 1'b1) begin fails++; $display("FAIL add_latency got ov=%b exp 1", ifz.out_valid); end
    tests++; if (ifz.out_result !== 32'd5 || ifz.out_zero !== 1'b0) begin
      fails++; $display("FAIL add_result got %h z=%b exp 5 z=0", ifz.out_result, ifz.out_zero); end
    tests++; if (ifz.out_rd !== 3'd1 || ifz.out_illegal !== 1'b0) begin
      fails++; $display("FAIL add_rd got rd=%0d ill=%b exp 1 0", ifz.out_rd, ifz.out_illegal); end
    tests++; if (ifz.alu_op2 !== 32'd0) begin fails++; $display("FAIL resp_op2_gated got %h exp 0", ifz.alu_op2); end
    step();
    tests++; if (ifz.out_valid !== 1'b0 || ifz.in_ready !== 1'b1) begin
      fails++; $display("FAIL add_done got ov=%b rdy=%b exp 0 1", ifz.out_valid, ifz.in_ready); end
    tests++; if (ifz.alu_op2 !== 32'd0) begin fails++; $display("FAIL idle_op2_gated got %h exp 0", ifz.alu_op2); end
  endtask

  task automatic test_sub_sltu();
    send(mk(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0005));
    step(); step();
    send(mk(4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000));
    tests++; if (ifz.alu_op1 !== 32'd5 || ifz.alu_op2 !== 32'd5 || ifz.alu_op !== 4'd1) begin
      fails++; $display("FAIL sub_exec got %h %h op=%h exp 5 5 1", ifz.alu_op1, ifz.alu_op2, ifz.alu_op); end
    step();
    tests++; if (ifz.out_result !== 32'd0 || ifz.out_zero !== 1'b1 || ifz.out_rd !== 3'd3) begin
      fails++; $display("FAIL sub_result got %h z=%b rd=%0d exp 0 1 3", ifz.out_result, ifz.out_zero, ifz.out_rd); end
    step();
    send(mk(4'd7, 3'd4, 3'd0, 3'd1, 1'b0, 16'h0000));
    step();
    tests++; if (ifz.out_result !== 32'd1 || ifz.out_zero !== 1'b0) begin
      fails++; $display("FAIL sltu_result got %h z=%b exp 1 0", ifz.out_result, ifz.out_zero); end
    step();
  endtask

  task automatic test_ops();
    // r1 = 5; opcodes 2..6 with immediates
    logic [15:0] imm_t [5];
    logic [31:0] exp_t [5];
    imm_t = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd1};
    exp_t = '{32'd1, 32'd7, 32'd6, 32'd40, 32'd2};
    for (int i = 0; i < 5; i++) begin
      send(mk(4'(i + 2), 3'd7, 3'd1, 3'd0, 1'b1, imm_t[i]));
      tests++; if (ifz.alu_op !== 4'(i + 2)) begin fails++; $display("FAIL op%0d_sel got %h exp %h", i + 2, ifz.alu_op, 4'(i + 2)); end
      step();
      tests++; if (ifz.out_result !== exp_t[i]) begin fails++; $display("FAIL op%0d_result got %h exp %h", i + 2, ifz.out_result, exp_t[i]); end
      step();
    end
  endtask

  task automatic test_illegal();
    // r1 = 5; the ADD the ALU sees would give 8, must be reported as 0
    send(mk(4'hA, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0003));
    tests++; if (ifz.alu_op !== 4'd0) begin fails++; $display("FAIL ill_alu_op got %h exp 0", ifz.alu_op); end
    step();
    tests++; if (ifz.out_illegal !== 1'b1 || ifz.out_result !== 32'd0 || ifz.out_rd !== 3'd5) begin
      fails++; $display("FAIL ill_record got ill=%b res=%h rd=%0d exp 1 0 5", ifz.out_illegal, ifz.out_result, ifz.out_rd); end
    step();
    // ALU sees 0 + 0 here and raises zero; the record must still say 0
    send(mk(4'hF, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0000));
    step();
    tests++; if (ifz.out_zero !== 1'b0 || ifz.out_illegal !== 1'b1) begin
      fails++; $display("FAIL ill_zero got z=%b ill=%b exp 0 1", ifz.out_zero, ifz.out_illegal); end
    step();
    send(mk(4'd0, 3'd6, 3'd5, 3'd0, 1'b1, 16'h0000));
    step();
    tests++; if (ifz.out_result !== 32'd0 || ifz.out_illegal !== 1'b0) begin
      fails++; $display("FAIL ill_no_wb got %h ill=%b exp 0 0", ifz.out_result, ifz.out_illegal); end
    step();
  endtask

  task automatic test_backpressure();
    send(mk(4'd0, 3'd7, 3'd1, 3'd0, 1'b1, 16'h0002));
    step();
    ifz.out_ready = 1'b0;
    ifz.in_valid  = 1'b1;
    ifz.in_instr  = mk(4'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h1234);
    for (int c = 0; c < 4; c++) begin
      step();
      tests++; if (ifz.out_valid !== 1'b1 || ifz.out_result !== 32'd7 || ifz.out_rd !== 3'd7) begin
        fails++; $display("FAIL bp_hold%0d got ov=%b res=%h rd=%0d exp 1 7 7", c, ifz.out_valid, ifz.out_result, ifz.out_rd); end
      tests++; if (ifz.in_ready !== 1'b0 || ifz.busy !== 1'b1) begin
        fails++; $display("FAIL bp_flags%0d got rdy=%b busy=%b exp 0 1", c, ifz.in_ready, ifz.busy); end
    end
    ifz.in_valid  = 1'b0;
    ifz.out_ready = 1'b1;
    step();
    tests++; if (ifz.out_valid !== 1'b0 || ifz.in_ready !== 1'b1 || ifz.busy !== 1'b0) begin
      fails++; $display("FAIL bp_release got ov=%b rdy=%b busy=%b exp 0 1 0", ifz.out_valid, ifz.in_ready, ifz.busy); end
  endtask

  task automatic test_back_to_back();
    // in_valid held high: A accepted at N, B must be accepted at N+3 and see A's write
    @(negedge clk);
    ifz.in_valid = 1'b1;
    ifz.in_instr = mk(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0009);
    @(posedge clk); #1;
    ifz.in_instr = mk(4'd0, 3'd3, 3'd2, 3'd0, 1'b1, 16'h0001);
    step();
    tests++; if (ifz.in_ready !== 1'b0 || ifz.out_result !== 32'd9) begin
      fails++; $display("FAIL b2b_a got rdy=%b res=%h exp 0 9", ifz.in_ready, ifz.out_result); end
    step();
    tests++; if (ifz.in_ready !== 1'b1 || ifz.out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_gap got rdy=%b ov=%b exp 1 0", ifz.in_ready, ifz.out_valid); end
    step();
    ifz.in_valid = 1'b0;
    tests++; if (ifz.busy !== 1'b1 || ifz.alu_op1 !== 32'd9) begin
      fails++; $display("FAIL b2b_b_exec got busy=%b op1=%h exp 1 9", ifz.busy, ifz.alu_op1); end
    step();
    tests++; if (ifz.out_result !== 32'd10 || ifz.out_rd !== 3'd3) begin
      fails++; $display("FAIL b2b_b got %h rd=%0d exp 10 3", ifz.out_result, ifz.out_rd); end
    step();
  endtask

  task automatic test_sext();
    send(mk(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF));
    step();
    tests++; if (ifs.out_result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sext_result got %h exp ffffffff", ifs.out_result); end
    tests++; if (ifz.out_result !== 32'h0000_FFFF) begin fails++; $display("FAIL zext_result got %h exp 0000ffff", ifz.out_result); end
    step();
  endtask

  task automatic test_r0_write();
    send(mk(4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0007));
    step();
    tests++; if (ifz.out_result !== 32'd7 || ifz.out_rd !== 3'd0) begin
      fails++; $display("FAIL r0_report got %h rd=%0d exp 7 0", ifz.out_result, ifz.out_rd); end
    step();
    send(mk(4'd3, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000));
    tests++; if (ifz.alu_op1 !== 32'd0 || ifz.alu_op2 !== 32'd0) begin
      fails++; $display("FAIL r0_read got %h %h exp 0 0", ifz.alu_op1, ifz.alu_op2); end
    step(); step();
  endtask

  task automatic test_reset_in_exec();
    send(mk(4'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0055));
    rst_n = 1'b0;
    #1;
    tests++; if (ifz.busy !== 1'b0 || ifz.in_ready !== 1'b1 || ifz.alu_op2 !== 32'd0) begin
      fails++; $display("FAIL rst_exec_async got busy=%b rdy=%b op2=%h exp 0 1 0", ifz.busy, ifz.in_ready, ifz.alu_op2); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      tests++; if (ifz.out_valid !== 1'b0) begin fails++; $display("FAIL rst_exec_ov%0d got %b exp 0", c, ifz.out_valid); end
    end
    // r4 abandoned, r2 (was 9) cleared by reset
    send(mk(4'd3, 3'd5, 3'd4, 3'd2, 1'b0, 16'h0000));
    step();
    tests++; if (ifz.out_valid !== 1'b1 || ifz.out_result !== 32'd0) begin
      fails++; $display("FAIL rst_exec_regs got ov=%b res=%h exp 1 0", ifz.out_valid, ifz.out_result); end
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add_imm();
    test_sub_sltu();
    test_ops();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_sext();
    test_r0_write();
    test_reset_in_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
